// File: rtl/register_file.sv
// ---------------------------------------------------------------------------
// register_file
//   DEPTH x WIDTH register file with one synchronous write port and two
//   independent combinational read ports. Entry 0 can optionally be a
//   constant-zero register. Write-to-read forwarding can optionally make
//   write data visible on the read ports in the same cycle as the write.
//
// Parameters
//   WIDTH    bits per entry (1..32)
//   DEPTH    number of entries, power of two (2..16)
//   ZERO_REG 1: entry 0 always reads 0 and ignores writes
//   BYPASS   1: a pending write is forwarded to matching read ports
//
// Ports
//   clk      clock, all state changes on the rising edge
//   nclr     synchronous active-low clear of every entry
//   wen      write enable
//   waddr    write address
//   wdata    write data
//   raddr_a  read port A address    rdata_a  read port A data
//   raddr_b  read port B address    rdata_b  read port B data
// ---------------------------------------------------------------------------
module register_file #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 0,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             nclr,
    input  logic             wen,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_live;
    logic             wr_blocked;

    // A write is live only outside reset; the clear always takes priority.
    assign wr_live    = nclr & wen;
    assign wr_blocked = (ZERO_REG != 0) && (waddr == '0);

    always_ff @(posedge clk) begin
        if (!nclr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wen && !wr_blocked) begin
            mem[waddr] <= wdata;
        end
    end

    // Read selection order: the zero register wins over forwarding, and
    // forwarding wins over the stored value.
    function automatic logic [WIDTH-1:0] read_sel(
        input logic [AW-1:0]    addr,
        input logic [WIDTH-1:0] stored,
        input logic             live,
        input logic [AW-1:0]    wa,
        input logic [WIDTH-1:0] wd
    );
        logic [WIDTH-1:0] res;
        res = stored;
        if ((BYPASS != 0) && live && (addr == wa)) begin
            res = wd;
        end
        if ((ZERO_REG != 0) && (addr == '0)) begin
            res = '0;
        end
        return res;
    endfunction

    always_comb begin
        rdata_a = read_sel(raddr_a, mem[raddr_a], wr_live, waddr, wdata);
    end

    always_comb begin
        rdata_b = read_sel(raddr_b, mem[raddr_b], wr_live, waddr, wdata);
    end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter WIDTH, default 8, bits per entry; legal range 1..32.
REQ-002 Parameter DEPTH, default 4, number of entries; SHALL be a power of two, 2..16.
REQ-003 Parameter ZERO_REG, default 0; 1 makes entry 0 a constant-zero register.
REQ-004 Parameter BYPASS, default 0; 1 enables write-to-read forwarding.
REQ-005 Derived AW = log2(DEPTH), the address width.
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 nclr  input  1  reset, synchronous and active-low.
REQ-008 wen  input  1  write enable.
REQ-009 waddr  input  AW  write address.
REQ-010 wdata  input  WIDTH  write data.
REQ-011 raddr_a  input  AW  read port A address.
REQ-012 rdata_a  output  WIDTH  read port A data.
REQ-013 raddr_b  input  AW  read port B address.
REQ-014 rdata_b  output  WIDTH  read port B data.

Function
REQ-015 Storage SHALL be DEPTH entries of WIDTH bits, updated only on the rising edge of clk.
REQ-016 Write: at a rising edge with nclr=1 and wen=1, entry[waddr] SHALL take wdata; all other entries hold.
REQ-017 With wen=0, all entries SHALL hold.
REQ-018 Reads SHALL be combinational (zero-cycle latency): rdata_x = entry[raddr_x], with no clock involvement.
REQ-019 Ports A and B SHALL be fully independent and may address the same entry, each returning the same value.
REQ-020 Without bypass, a write SHALL become visible on the read ports immediately after the writing edge, never before it.
REQ-021 BYPASS=1, nclr=1, wen=1, raddr_x==waddr: rdata_x SHALL equal wdata combinationally, before the edge.
REQ-022 BYPASS=1 with nclr=0: no forwarding; the read ports SHALL show stored values.
REQ-023 ZERO_REG=1: writes to address 0 SHALL be discarded.
REQ-024 ZERO_REG=1: reads of address 0 SHALL return 0, overriding bypass.
REQ-025 ZERO_REG=0: entry 0 SHALL behave like every other entry.
REQ-026 Wrap-around: none; every AW-bit address is a valid entry (DEPTH is a power of two).
REQ-027 Successive writes to the same address on consecutive edges SHALL leave the last value written.

Reset
REQ-028 At a rising edge with nclr=0, every entry SHALL become 0, regardless of wen, waddr and wdata.
REQ-029 A write coincident with reset SHALL be lost.
REQ-030 Between edges, nclr SHALL have no effect on the stored state (synchronous only).
REQ-031 After a reset edge, both read ports SHALL return 0 for every address until a subsequent write.
REQ-032 Deasserting nclr mid-sequence SHALL resume normal writes at the first edge with nclr=1.
REQ-033 The state before the first reset edge is undefined; the bench SHALL apply reset first.

Verification
REQ-034 Defaults, reset for 1 edge, then read all 4 addresses on both ports -> 0x00 everywhere.
REQ-035 Write 0xA5->addr1 and 0x3C->addr2, then raddr_a=1, raddr_b=2 -> rdata_a=0xA5, rdata_b=0x3C; both ports at addr1 -> 0xA5 on each.
REQ-036 BYPASS=0: wen=1, waddr=3, wdata=0x77, raddr_a=3 before the edge -> old value; after the edge -> 0x77.
REQ-037 BYPASS=1, same stimulus as REQ-036 -> 0x77 before the edge; then nclr=0, wen=1, waddr=3, wdata=0x11 -> no forwarding, and all entries 0 after the edge.
REQ-038 ZERO_REG=1: write 0xFF->addr0 -> reads of addr0 return 0x00; with BYPASS=1 and a pending write to addr0, still 0x00.
REQ-039 WIDTH=16, DEPTH=16: write addr=k with data 0x1000+k for k=0..15, read back all 16 on both ports -> exact match; toggle nclr low between edges without an edge -> data retained.
